// File: rtl/io_pkg.sv
// Shared types and helpers for the multi-channel I/O interrupt unit.
package io_pkg;

    // Interrupt sequencer states: IDLE waits for a request, PENDING holds R.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } irq_state_t;

    // Largest supported build; request vectors are padded to this size.
    localparam int MAX_CHANNELS = 16;
    localparam int MAX_REQ      = 2 * MAX_CHANNELS;
    localparam int IDX_W        = $clog2(MAX_REQ);
    localparam int MAX_SEL_W    = $clog2(MAX_CHANNELS);

    // Result of a priority search: found flag plus the winning index.
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } irq_pick_t;

    // Channel-select width; a one-channel build still gets a 1-bit select.
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Lowest set bit wins (bit 0 is the highest-priority source).
    function automatic irq_pick_t priority_index(input logic [MAX_REQ-1:0] req);
        irq_pick_t pick;
        pick = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick.found = 1'b1;
                pick.idx   = IDX_W'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/io_channel.sv
// One input character channel (INPR/FGI) and one output channel (OUTR/FGO).
// Device side uses valid/ready: a transfer happens on an edge where both are 1.
// dev_in_ready is !fgi and dev_out_valid is !fgo, so each flag doubles as the
// "buffer full / buffer empty" indication for its side.
module io_channel
    import io_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             boot,
    input  logic [WIDTH-1:0] dev_in_data,
    input  logic             dev_in_valid,
    output logic             dev_in_ready,
    output logic [WIDTH-1:0] dev_out_data,
    output logic             dev_out_valid,
    input  logic             dev_out_ready,
    input  logic             inp_stb,
    input  logic             out_stb,
    input  logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] inpr,
    output logic             fgi,
    output logic             fgo
);

    logic [WIDTH-1:0] inpr_q, inpr_d;
    logic [WIDTH-1:0] outr_q, outr_d;
    logic             fgi_q, fgi_d;
    logic             fgo_q, fgo_d;

    // Next-state for both flags and data registers; CPU strobes act only when
    // their flag allows it, and the device side can never collide with them
    // because its handshake is gated by the same flag.
    always_comb begin
        inpr_d = inpr_q;
        outr_d = outr_q;
        fgi_d  = fgi_q;
        fgo_d  = fgo_q;
        if (inp_stb && fgi_q) begin
            fgi_d = 1'b0;
        end else if (dev_in_valid && !fgi_q) begin
            inpr_d = dev_in_data;
            fgi_d  = 1'b1;
        end
        if (out_stb && fgo_q) begin
            outr_d = out_data;
            fgo_d  = 1'b0;
        end else if (dev_out_ready && !fgo_q) begin
            fgo_d = 1'b1;
        end
    end

    // Channel state registers with async reset and synchronous boot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inpr_q <= '0;
            outr_q <= '0;
            fgi_q  <= 1'b0;
            fgo_q  <= 1'b1;
        end else if (boot) begin
            inpr_q <= '0;
            outr_q <= '0;
            fgi_q  <= 1'b0;
            fgo_q  <= 1'b1;
        end else begin
            inpr_q <= inpr_d;
            outr_q <= outr_d;
            fgi_q  <= fgi_d;
            fgo_q  <= fgo_d;
        end
    end

    assign dev_in_ready  = !fgi_q;
    assign dev_out_valid = !fgo_q;
    assign dev_out_data  = outr_q;
    assign inpr          = inpr_q;
    assign fgi           = fgi_q;
    assign fgo           = fgo_q;

endmodule

// File: rtl/io_interrupt_unit.sv
// Multi-channel I/O and priority interrupt unit: CPU strobe decode, IEN,
// the IDLE/PENDING sequencer that drives R, and the latched vector.
module io_interrupt_unit
    import io_pkg::*;
#(
    parameter  int CHANNELS    = 4,
    parameter  int WIDTH       = 8,
    parameter  int ADDR_WIDTH  = 12,
    parameter  int VECTOR_BASE = 0,
    localparam int SEL_W       = sel_width(CHANNELS)
) (
    input  logic                      clock_in,
    input  logic                      reset_n_in,
    input  logic                      boot_in,
    input  logic [CHANNELS*WIDTH-1:0] dev_in_data_in,
    input  logic [CHANNELS-1:0]       dev_in_valid_in,
    output logic [CHANNELS-1:0]       dev_in_ready_out,
    output logic [CHANNELS*WIDTH-1:0] dev_out_data_out,
    output logic [CHANNELS-1:0]       dev_out_valid_out,
    input  logic [CHANNELS-1:0]       dev_out_ready_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      inp_in,
    input  logic                      out_in,
    input  logic                      ski_in,
    input  logic                      sko_in,
    input  logic                      ion_in,
    input  logic                      iof_in,
    input  logic [WIDTH-1:0]          out_data_in,
    output logic [WIDTH-1:0]          inpr_out,
    output logic                      skip_out,
    input  logic                      boundary_in,
    input  logic                      intack_in,
    output logic                      r_out,
    output logic [ADDR_WIDTH-1:0]     vector_out,
    output logic                      ien_out,
    output logic [CHANNELS-1:0]       fgi_out,
    output logic [CHANNELS-1:0]       fgo_out,
    output logic                      overrun_out,
    output logic                      irq_state_out
);

    logic [CHANNELS-1:0] fgi_w, fgo_w, inp_hit, out_hit;
    logic [WIDTH-1:0]    inpr_w [CHANNELS];
    logic                sel_ok, fgi_sel, fgo_sel;
    logic [MAX_REQ-1:0]  req;
    irq_pick_t           pick;
    logic                take;
    logic [ADDR_WIDTH-1:0] vector_new;

    irq_state_t            state_q, state_d;
    logic                  ien_q, ien_d;
    logic [ADDR_WIDTH-1:0] vector_q, vector_d;
    logic                  overrun_q, overrun_d;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        io_channel #(.WIDTH(WIDTH)) u_ch (
            .clk          (clock_in),
            .rst_n        (reset_n_in),
            .boot         (boot_in),
            .dev_in_data  (dev_in_data_in[c*WIDTH +: WIDTH]),
            .dev_in_valid (dev_in_valid_in[c]),
            .dev_in_ready (dev_in_ready_out[c]),
            .dev_out_data (dev_out_data_out[c*WIDTH +: WIDTH]),
            .dev_out_valid(dev_out_valid_out[c]),
            .dev_out_ready(dev_out_ready_in[c]),
            .inp_stb      (inp_hit[c]),
            .out_stb      (out_hit[c]),
            .out_data     (out_data_in),
            .inpr         (inpr_w[c]),
            .fgi          (fgi_w[c]),
            .fgo          (fgo_w[c])
        );
    end

    // Decode the CPU strobes onto the addressed channel; an out-of-range
    // select reads as an empty, flagless channel so every strobe is a no-op.
    always_comb begin
        sel_ok   = (int'(sel_in) < CHANNELS);
        inp_hit  = '0;
        out_hit  = '0;
        fgi_sel  = 1'b0;
        fgo_sel  = 1'b0;
        inpr_out = '0;
        if (sel_ok) begin
            inp_hit[sel_in] = inp_in;
            out_hit[sel_in] = out_in;
            fgi_sel         = fgi_w[sel_in];
            fgo_sel         = fgo_w[sel_in];
            inpr_out        = inpr_w[sel_in];
        end
        skip_out  = (ski_in & fgi_sel) | (sko_in & fgo_sel);
        overrun_d = sel_ok & ((inp_in & ~fgi_sel) | (out_in & ~fgo_sel));
    end

    // Priority search over {fgo, fgi}; fgi[0] is the highest-priority source.
    always_comb begin
        req                   = '0;
        req[2*CHANNELS-1:0]   = {fgo_w, fgi_w};
        pick                  = priority_index(req);
        take                  = ien_q & pick.found & boundary_in;
        vector_new            = ADDR_WIDTH'(VECTOR_BASE + int'(pick.idx));
    end

    // Sequencer next state; PENDING ignores requests until acknowledged.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = PENDING;
            PENDING: if (intack_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // IEN and vector next values; acknowledge overrides any ION/IOF.
    always_comb begin
        ien_d = ien_q;
        if (ion_in) ien_d = 1'b1;
        if (iof_in) ien_d = 1'b0;
        if (state_q == PENDING && intack_in) ien_d = 1'b0;
        vector_d = vector_q;
        if (state_q == IDLE && take) vector_d = vector_new;
    end

    // Sequencer and control registers with async reset and synchronous boot.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= IDLE;
            ien_q     <= 1'b0;
            vector_q  <= '0;
            overrun_q <= 1'b0;
        end else if (boot_in) begin
            state_q   <= IDLE;
            ien_q     <= 1'b0;
            vector_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ien_q     <= ien_d;
            vector_q  <= vector_d;
            overrun_q <= overrun_d;
        end
    end

    // Sequencer outputs: R is simply "in PENDING".
    always_comb begin
        r_out         = (state_q == PENDING);
        irq_state_out = state_q;
        vector_out    = vector_q;
        ien_out       = ien_q;
        overrun_out   = overrun_q;
        fgi_out       = fgi_w;
        fgo_out       = fgo_w;
    end

endmodule

// File: tb/tb_io_interrupt_unit.sv
// Directed bench for io_interrupt_unit: a 4-channel build for the main
// function and a 6-channel build for out-of-range channel selects.
module tb_io_interrupt_unit;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    // 4-channel DUT signals
    logic        boot;
    logic [31:0] dev_in_data;
    logic [3:0]  dev_in_valid, dev_in_ready, dev_out_valid, dev_out_ready;
    logic [31:0] dev_out_data;
    logic [1:0]  sel;
    logic        inp, outs, ski, sko, ion, iof, boundary, intack;
    logic [7:0]  out_data, inpr;
    logic        skip, r, ien, overrun, irq_state;
    logic [11:0] vector;
    logic [3:0]  fgi, fgo;

    // 6-channel DUT signals
    logic [47:0] b_dev_in_data, b_dev_out_data;
    logic [5:0]  b_dev_in_valid, b_dev_in_ready, b_dev_out_valid, b_dev_out_ready;
    logic [2:0]  b_sel;
    logic        b_inp, b_out, b_ski, b_sko;
    logic [7:0]  b_out_data, b_inpr;
    logic        b_skip, b_r, b_ien, b_overrun, b_irq_state;
    logic [11:0] b_vector;
    logic [5:0]  b_fgi, b_fgo;

    io_interrupt_unit #(.CHANNELS(4)) u_dut (
        .clock_in(clk), .reset_n_in(rst_n), .boot_in(boot),
        .dev_in_data_in(dev_in_data), .dev_in_valid_in(dev_in_valid),
        .dev_in_ready_out(dev_in_ready), .dev_out_data_out(dev_out_data),
        .dev_out_valid_out(dev_out_valid), .dev_out_ready_in(dev_out_ready),
        .sel_in(sel), .inp_in(inp), .out_in(outs), .ski_in(ski), .sko_in(sko),
        .ion_in(ion), .iof_in(iof), .out_data_in(out_data), .inpr_out(inpr),
        .skip_out(skip), .boundary_in(boundary), .intack_in(intack),
        .r_out(r), .vector_out(vector), .ien_out(ien), .fgi_out(fgi),
        .fgo_out(fgo), .overrun_out(overrun), .irq_state_out(irq_state)
    );

    io_interrupt_unit #(.CHANNELS(6)) u_dut6 (
        .clock_in(clk), .reset_n_in(rst_n), .boot_in(1'b0),
        .dev_in_data_in(b_dev_in_data), .dev_in_valid_in(b_dev_in_valid),
        .dev_in_ready_out(b_dev_in_ready), .dev_out_data_out(b_dev_out_data),
        .dev_out_valid_out(b_dev_out_valid), .dev_out_ready_in(b_dev_out_ready),
        .sel_in(b_sel), .inp_in(b_inp), .out_in(b_out), .ski_in(b_ski), .sko_in(b_sko),
        .ion_in(1'b0), .iof_in(1'b0), .out_data_in(b_out_data), .inpr_out(b_inpr),
        .skip_out(b_skip), .boundary_in(1'b0), .intack_in(1'b0),
        .r_out(b_r), .vector_out(b_vector), .ien_out(b_ien), .fgi_out(b_fgi),
        .fgo_out(b_fgo), .overrun_out(b_overrun), .irq_state_out(b_irq_state)
    );

    // Clock and reset: 10 ns period; reset is driven from the stimulus block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        boot = 0; dev_in_data = '0; dev_in_valid = '0; dev_out_ready = '0;
        sel = '0; inp = 0; outs = 0; ski = 0; sko = 0; ion = 0; iof = 0;
        boundary = 0; intack = 0; out_data = '0;
        b_dev_in_data = '0; b_dev_in_valid = '0; b_dev_out_ready = '0;
        b_sel = '0; b_inp = 0; b_out = 0; b_ski = 0; b_sko = 0; b_out_data = '0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        idle_inputs();
        #23;
        // Reset values
        check("rst_fgi", fgi, 4'h0);
        check("rst_fgo", fgo, 4'hF);
        check("rst_out_valid", dev_out_valid, 4'h0);
        check("rst_in_ready", dev_in_ready, 4'hF);
        check("rst_r", r, 0);
        check("rst_ien", ien, 0);
        check("rst_vector", vector, 12'h000);
        rst_n = 1'b1;
        tick();

        // Input path on channel 2
        dev_in_data[23:16] = 8'h41; dev_in_valid[2] = 1;
        tick();
        dev_in_valid = '0; dev_in_data = '0;
        check("in_fgi_set", fgi, 4'b0100);
        check("in_ready_low", dev_in_ready, 4'b1011);
        sel = 2; ski = 1; #1;
        check("ski_skip", skip, 1);
        ski = 0; sel = 1; ski = 1; #1;
        check("ski_noskip", skip, 0);
        ski = 0; sel = 2; inp = 1; #1;
        check("inp_inpr", inpr, 8'h41);
        tick();
        inp = 0;
        check("inp_fgi_clr", fgi, 4'b0000);
        check("inp_no_overrun", overrun, 0);
        // INP with the flag already clear
        inp = 1;
        tick();
        inp = 0;
        check("inp_overrun", overrun, 1);
        check("inp_overrun_fgi", fgi, 4'b0000);
        tick();
        check("overrun_one_cycle", overrun, 0);

        // Output path on channel 1
        sel = 1; outs = 1; out_data = 8'h5A;
        tick();
        outs = 0;
        check("out_valid", dev_out_valid, 4'b0010);
        check("out_data", dev_out_data[15:8], 8'h5A);
        check("out_fgo", fgo, 4'b1101);
        check("out_no_overrun", overrun, 0);
        sko = 1; #1;
        check("sko_noskip", skip, 0);
        sko = 0;
        outs = 1; out_data = 8'h33;
        tick();
        outs = 0;
        check("out_overrun", overrun, 1);
        check("out_data_kept", dev_out_data[15:8], 8'h5A);
        dev_out_ready[1] = 1;
        tick();
        dev_out_ready = '0;
        check("out_accept_fgo", fgo, 4'hF);
        check("out_accept_valid", dev_out_valid, 4'h0);

        // Boot in the middle of traffic
        dev_in_data[7:0] = 8'h99; dev_in_valid[0] = 1;
        sel = 3; outs = 1; out_data = 8'hC3; ion = 1;
        tick();
        dev_in_valid = '0; outs = 0; ion = 0;
        check("pre_boot_fgi", fgi, 4'b0001);
        check("pre_boot_fgo", fgo, 4'b0111);
        check("pre_boot_ien", ien, 1);
        boot = 1;
        tick();
        boot = 0;
        check("boot_fgi", fgi, 4'h0);
        check("boot_fgo", fgo, 4'hF);
        check("boot_ien", ien, 0);
        check("boot_outr", dev_out_data, 32'h0);
        sel = 0; #1;
        check("boot_inpr", inpr, 8'h00);

        // Priority: fgi[3] beats all fgo bits
        dev_in_data[31:24] = 8'h77; dev_in_valid[3] = 1; boundary = 1;
        tick();
        dev_in_valid = '0;
        check("ien0_no_r", r, 0);
        boundary = 0; ion = 1;
        tick();
        ion = 0;
        check("ion_ien", ien, 1);
        tick();
        check("boundary0_idle", r, 0);
        boundary = 1;
        tick();
        boundary = 0;
        check("take_r", r, 1);
        check("take_vector", vector, 12'd3);
        check("take_state", irq_state, 1);
        sel = 3; inp = 1;
        tick();
        inp = 0;
        check("pending_fgi_clr", fgi, 4'h0);
        check("pending_vector_hold", vector, 12'd3);
        check("pending_r_hold", r, 1);
        iof = 1;
        tick();
        iof = 0;
        check("pending_iof", ien, 0);
        ion = 1;
        tick();
        ion = 0;
        check("pending_ion", ien, 1);

        // Acknowledge together with ION: IEN ends up clear
        intack = 1; ion = 1;
        tick();
        intack = 0; ion = 0;
        check("ack_r", r, 0);
        check("ack_ien", ien, 0);
        boundary = 1;
        tick();
        tick();
        check("no_reentry", r, 0);
        ion = 1;
        tick();
        ion = 0;
        check("reion_r_still0", r, 0);
        tick();
        check("reion_r", r, 1);
        check("reion_vector", vector, 12'd4);
        boundary = 0;
        intack = 1;
        tick();
        intack = 0;
        check("ack2_r", r, 0);
        intack = 1;
        tick();
        intack = 0;
        check("idle_intack_ignored", irq_state, 0);

        // Simultaneous ION and IOF
        ion = 1;
        tick();
        check("ion_again", ien, 1);
        iof = 1;
        tick();
        ion = 0; iof = 0;
        check("ion_iof_both", ien, 0);

        // Out-of-range select on the 6-channel build
        b_sel = 5; b_out = 1; b_out_data = 8'hAB;
        tick();
        b_out = 0;
        check("b_inrange_out", b_fgo, 6'b011111);
        b_dev_in_data[47:40] = 8'h5C; b_dev_in_valid[5] = 1;
        tick();
        b_dev_in_valid = '0;
        b_sel = 7; b_out = 1; b_inp = 1; b_ski = 1; b_sko = 1; #1;
        check("b_sel7_skip", b_skip, 0);
        check("b_sel7_inpr", b_inpr, 8'h00);
        tick();
        b_out = 0; b_inp = 0; b_ski = 0; b_sko = 0;
        check("b_sel7_fgo", b_fgo, 6'b011111);
        check("b_sel7_fgi", b_fgi, 6'b100000);
        check("b_sel7_overrun", b_overrun, 0);
        b_sel = 6; b_out = 1; #1;
        check("b_sel6_inpr", b_inpr, 8'h00);
        tick();
        b_out = 0;
        check("b_sel6_fgo", b_fgo, 6'b011111);
        b_sel = 5; #1;
        check("b_sel5_inpr", b_inpr, 8'h5C);

        // Asynchronous reset while PENDING
        ion = 1;
        tick();
        ion = 0; boundary = 1;
        tick();
        boundary = 0;
        check("pre_async_r", r, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_r", r, 0);
        check("async_rst_fgo", fgo, 4'hF);
        #10;
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
